// File: rtl/lane_obstacle_ctrl.sv
// Lane scroller and frog-cell hazard lookup.
// Ten lanes scroll on a shared step prescaler, each with its own divider.
module lane_obstacle_ctrl #(
  parameter int c_STEP_COUNT  = 13000000,
  parameter int c_GAME_WIDTH  = 14,
  parameter int c_GAME_HEIGHT = 15
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Game_Active,
  input  logic [5:0] i_Frogger_X,
  input  logic [5:0] i_Frogger_Y,
  output logic       o_Collided,
  output logic       o_On_Log,
  output logic [3:0] o_Bitmap_Data,
  output logic       o_Log_Shift
);

  localparam int c_NL = 10;
  localparam int c_CW =
    (c_STEP_COUNT > 1) ? $clog2(c_STEP_COUNT) : 1;

  // lanes 0-4 are rows 1-5 (logs), lanes 5-9 are rows 9-13 (cars)
  localparam logic [13:0] c_INIT [c_NL] = '{
    14'h078F, 14'h1C3C, 14'h0CE7, 14'h01F8, 14'h070E,
    14'h0081, 14'h0418, 14'h0842, 14'h1020, 14'h020C
  };
  localparam logic [1:0] c_SPD_M1 [c_NL] = '{
    2'd2, 2'd1, 2'd3, 2'd1, 2'd2,
    2'd0, 2'd1, 2'd0, 2'd2, 2'd1
  };
  localparam logic [c_NL-1:0] c_LEFT = 10'b10_1011_1111;

  logic [c_CW-1:0]         presc_q;
  logic                    step;
  logic [1:0]              div_q  [c_NL];
  logic [c_GAME_WIDTH-1:0] lane_q [c_NL];
  logic [c_NL-1:0]         due;

  logic       in_range;
  logic       is_goal;
  logic       is_water;
  logic       is_road;
  logic       is_pad;
  logic       hit;
  logic [3:0] li;
  logic [3:0] code_d;
  logic [63:0] row_bits;

  assign step = i_Game_Active &&
    (presc_q == c_CW'(c_STEP_COUNT - 1));

  always_ff @(posedge i_Clk) begin
    if (i_Reset)
      presc_q <= '0;
    else if (i_Game_Active)
      presc_q <= step ? '0 : presc_q + c_CW'(1);
  end

  always_comb begin
    due = '0;
    for (int i = 0; i < c_NL; i++)
      due[i] = step && (div_q[i] == c_SPD_M1[i]);
  end

  always_ff @(posedge i_Clk) begin
    for (int i = 0; i < c_NL; i++) begin
      if (i_Reset) begin
        div_q[i]  <= 2'd0;
        lane_q[i] <= c_GAME_WIDTH'(c_INIT[i]);
      end else if (step) begin
        div_q[i] <= due[i] ? 2'd0 : div_q[i] + 2'd1;
        if (due[i])
          lane_q[i] <= c_LEFT[i]
            ? {lane_q[i][0],
               lane_q[i][c_GAME_WIDTH-1:1]}
            : {lane_q[i][c_GAME_WIDTH-2:0],
               lane_q[i][c_GAME_WIDTH-1]};
      end
    end
  end

  always_comb begin
    in_range = (i_Frogger_X < 6'(c_GAME_WIDTH)) &&
               (i_Frogger_Y < 6'(c_GAME_HEIGHT));
    is_goal  = in_range && (i_Frogger_Y == 6'd0);
    is_water = in_range && (i_Frogger_Y >= 6'd1) &&
               (i_Frogger_Y <= 6'd5);
    is_road  = in_range && (i_Frogger_Y >= 6'd9) &&
               (i_Frogger_Y <= 6'd13);
    is_pad   = (i_Frogger_X == 6'd1) ||
               (i_Frogger_X == 6'd4) ||
               (i_Frogger_X == 6'd7) ||
               (i_Frogger_X == 6'd10);
    li = 4'd0;
    if (is_water)
      li = i_Frogger_Y[3:0] - 4'd1;
    else if (is_road)
      li = i_Frogger_Y[3:0] - 4'd4;
    row_bits = '0;
    if (is_water || is_road)
      row_bits = 64'(lane_q[li]);
    hit = row_bits[i_Frogger_X];
    code_d = 4'd0;
    unique case (1'b1)
      is_goal:  code_d = is_pad ? 4'd4 : 4'd6;
      is_water: code_d = hit ? 4'd3 : 4'd2;
      is_road:  code_d = hit ? 4'd5 : 4'd1;
      default:  code_d = 4'd0;
    endcase
  end

  // sampled against the pre-shift lane contents
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Collided    <= 1'b0;
      o_On_Log      <= 1'b0;
      o_Bitmap_Data <= 4'd0;
      o_Log_Shift   <= 1'b0;
    end else begin
      o_Collided    <= i_Game_Active && is_road && hit;
      o_On_Log      <= i_Game_Active && is_water && hit;
      o_Bitmap_Data <= code_d;
      o_Log_Shift   <= is_water && hit && due[li];
    end
  end

endmodule

// File: tb/tb_lane_obstacle_ctrl.sv
// Directed bench for lane_obstacle_ctrl.
// Step count is 4, so step pulses land on edges 4, 8, 12 after reset.
module tb_lane_obstacle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       act;
  logic [5:0] fx;
  logic [5:0] fy;
  logic       coll;
  logic       onlog;
  logic [3:0] data;
  logic       lshift;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lane_obstacle_ctrl #(
    .c_STEP_COUNT(4),
    .c_GAME_WIDTH(14),
    .c_GAME_HEIGHT(15)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Game_Active(act),
    .i_Frogger_X(fx),
    .i_Frogger_Y(fy),
    .o_Collided(coll),
    .o_On_Log(onlog),
    .o_Bitmap_Data(data),
    .o_Log_Shift(lshift)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [5:0] x,
                          input logic [5:0] y);
    rst = 1'b1;
    act = 1'b1;
    fx  = x;
    fy  = y;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; act = 1'b1; fx = 6'd0; fy = 6'd9;
    tick();
    tick();
    checks++;
    if ({coll, onlog, lshift, data} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=0000000",
               {coll, onlog, lshift, data});
    end
    rst = 1'b0;
  endtask

  task automatic test_car_hit();
    do_reset(6'd0, 6'd9);
    tick();
    checks++;
    if (coll !== 1'b1 || data !== 4'd5) begin
      errors++;
      $display("FAIL car_hit coll=%0b data=%0d exp 1/5",
               coll, data);
    end
    fx = 6'd1;
    tick();
    checks++;
    if (coll !== 1'b0 || data !== 4'd1) begin
      errors++;
      $display("FAIL car_miss coll=%0b data=%0d exp 0/1",
               coll, data);
    end
    fx = 6'd13;
    tick();
    tick();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pre coll=%0b exp=0", coll);
    end
    tick();
    checks++;
    if (coll !== 1'b1 || data !== 4'd5) begin
      errors++;
      $display("FAIL wrap_post coll=%0b data=%0d exp 1/5",
               coll, data);
    end
  endtask

  task automatic test_log_shift();
    int pulses;
    int at;
    do_reset(6'd0, 6'd1);
    pulses = 0;
    at = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (lshift === 1'b1) begin
        pulses++;
        at = e;
      end
      if (e == 1 || e == 13) begin
        checks++;
        if (onlog !== 1'b1 || data !== 4'd3) begin
          errors++;
          $display("FAIL on_log e=%0d log=%0b data=%0d exp 1/3",
                   e, onlog, data);
        end
      end
    end
    checks++;
    if (pulses != 1 || at != 12) begin
      errors++;
      $display("FAIL log_shift pulses=%0d at=%0d exp 1 at 12",
               pulses, at);
    end
    do_reset(6'd4, 6'd1);
    pulses = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (lshift === 1'b1) pulses++;
      if (e == 1) begin
        checks++;
        if (onlog !== 1'b0 || data !== 4'd2) begin
          errors++;
          $display("FAIL water log=%0b data=%0d exp 0/2",
                   onlog, data);
        end
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL no_log_shift pulses=%0d exp 0", pulses);
    end
  endtask

  task automatic test_right_lane();
    do_reset(6'd11, 6'd10);
    repeat (7) tick();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL right_e7 coll=%0b exp=0", coll);
    end
    tick();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL right_pre coll=%0b exp=0", coll);
    end
    tick();
    checks++;
    if (coll !== 1'b1 || data !== 4'd5) begin
      errors++;
      $display("FAIL right_post coll=%0b data=%0d exp 1/5",
               coll, data);
    end
    fx = 6'd4;
    tick();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL right_x4 coll=%0b exp=1", coll);
    end
    fx = 6'd3;
    tick();
    checks++;
    if (coll !== 1'b0 || data !== 4'd1) begin
      errors++;
      $display("FAIL right_x3 coll=%0b data=%0d exp 0/1",
               coll, data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(6'd0, 6'd11);
    repeat (3) tick();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL r11_e3 coll=%0b exp=0", coll);
    end
    fx = 6'd5;
    tick();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL move_shift_pre coll=%0b exp=0", coll);
    end
    tick();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL move_shift_post coll=%0b exp=1", coll);
    end
    fx = 6'd13; fy = 6'd9;
    tick();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_r9 coll=%0b exp=1", coll);
    end
    fx = 6'd8; fy = 6'd13;
    tick();
    tick();
    checks++;
    if (coll !== 1'b0) begin
      errors++;
      $display("FAIL r13_pre coll=%0b exp=0", coll);
    end
    tick();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL r13_post coll=%0b exp=1", coll);
    end
  endtask

  task automatic test_goal_safe();
    logic [5:0] xs [8] = '{6'd4, 6'd5, 6'd0, 6'd10,
                           6'd5, 6'd5, 6'd14, 6'd0};
    logic [5:0] ys [8] = '{6'd0, 6'd0, 6'd0, 6'd0,
                           6'd7, 6'd14, 6'd9, 6'd15};
    logic [3:0] cs [8] = '{4'd4, 4'd6, 4'd6, 4'd4,
                           4'd0, 4'd0, 4'd0, 4'd0};
    do_reset(6'd4, 6'd0);
    for (int i = 0; i < 8; i++) begin
      fx = xs[i];
      fy = ys[i];
      tick();
      checks++;
      if (data !== cs[i] || {coll, onlog, lshift} !== 3'b0) begin
        errors++;
        $display("FAIL cell x=%0d y=%0d data=%0d flags=%b exp %0d/000",
                 xs[i], ys[i], data, {coll, onlog, lshift}, cs[i]);
      end
    end
  endtask

  task automatic test_inactive();
    do_reset(6'd0, 6'd9);
    tick();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL pre_idle coll=%0b exp=1", coll);
    end
    act = 1'b0;
    for (int c = 0; c < 20; c++) begin
      fy = (c < 10) ? 6'd9 : 6'd1;
      tick();
      checks++;
      if ({coll, onlog, lshift} !== 3'b0 ||
          data !== ((c < 10) ? 4'd5 : 4'd3)) begin
        errors++;
        $display("FAIL idle c=%0d flags=%b data=%0d",
                 c, {coll, onlog, lshift}, data);
      end
    end
    fy = 6'd9;
    act = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      tick();
      checks++;
      if (coll !== ((a < 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL resume a=%0d coll=%0b exp=%0b",
                 a, coll, (a < 4));
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({coll, onlog, lshift, data} !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset got=%b exp=0000000",
               {coll, onlog, lshift, data});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (coll !== 1'b1 || data !== 4'd5) begin
      errors++;
      $display("FAIL restore_r9 coll=%0b data=%0d exp 1/5",
               coll, data);
    end
    fx = 6'd3; fy = 6'd10;
    tick();
    checks++;
    if (coll !== 1'b1) begin
      errors++;
      $display("FAIL restore_r10 coll=%0b exp=1", coll);
    end
    fx = 6'd4; fy = 6'd1;
    tick();
    checks++;
    if (onlog !== 1'b0 || data !== 4'd2) begin
      errors++;
      $display("FAIL restore_r1x4 log=%0b data=%0d exp 0/2",
               onlog, data);
    end
    fx = 6'd3;
    tick();
    checks++;
    if (onlog !== 1'b1 || data !== 4'd3) begin
      errors++;
      $display("FAIL restore_r1x3 log=%0b data=%0d exp 1/3",
               onlog, data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    act = 1'b0;
    fx  = 6'd0;
    fy  = 6'd0;
    test_reset();
    test_car_hit();
    test_log_shift();
    test_right_lane();
    test_back_to_back();
    test_goal_safe();
    test_inactive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_obstacle_ctrl.md
LANE_OBSTACLE_CTRL -- requirements
Module: lane_obstacle_ctrl

Interface
REQ-001 Parameter c_STEP_COUNT, default 13000000: clock cycles per lane step pulse; benches shall override it to 4.
REQ-002 Parameter c_GAME_WIDTH, default 14: number of columns (X 0..13).
REQ-003 Parameter c_GAME_HEIGHT, default 15: number of rows (Y 0..14; row 0 top goal, row 14 start).
REQ-004 i_Clk  in  1  single system clock; all logic on its rising edge.
REQ-005 i_Reset  in  1  synchronous, active-high reset.
REQ-006 i_Game_Active  in  1  high = lanes move and hazards reported.
REQ-007 i_Frogger_X  in  6  frog column.
REQ-008 i_Frogger_Y  in  6  frog row.
REQ-009 o_Collided  out  1  frog cell holds a car.
REQ-010 o_On_Log  out  1  frog cell is water covered by a log.
REQ-011 o_Bitmap_Data  out  4  cell code at the frog position.
REQ-012 o_Log_Shift  out  1  one-cycle pulse: the log under the frog moved one column left.

Function
REQ-013 Row classes: row 0 goal; rows 1-5 water (log lanes); rows 6-8 safe; rows 9-13 road (car lanes); row 14 safe.
REQ-014 Cell codes: 0 safe, 1 road, 2 open water, 3 log, 4 lily pad, 5 car, 6 goal wall.
REQ-015 Lily pads: row 0, columns 1, 4, 7 and 10; all other row-0 columns are code 6.
REQ-016 Each lane holds a 14-bit occupancy register; bit x = object at column x.
REQ-017 Prescaler counter 0..c_STEP_COUNT-1; it emits a one-cycle step pulse on the wrap cycle.
REQ-018 Each lane has its own divider; the lane shifts on every Nth step pulse, where N is its speed.
REQ-019 Log speeds, rows 1-5: 3, 2, 4, 2, 3; car speeds, rows 9-13: 1, 2, 1, 3, 2.
REQ-020 Shift left (rows 1-5, 9, 11, 13): new[x] = old[(x+1) mod 14], so bit 0 wraps into bit 13.
REQ-021 Shift right (rows 10, 12): new[x] = old[(x+13) mod 14], so bit 13 wraps into bit 0.
REQ-022 All lanes due on the same step pulse shall shift in the same cycle.
REQ-023 Outputs are registered, 1-cycle latency: values at edge n+1 come from the frog inputs and lane registers sampled at edge n.
REQ-024 A lane shift and a frog move in the same cycle: the output uses the pre-shift pattern; the post-shift pattern shows on the next cycle.
REQ-025 Water row: bit set -> code 3 and o_On_Log=1; bit clear -> code 2 and o_On_Log=0.
REQ-026 Road row: bit set -> code 5 and o_Collided=1; bit clear -> code 1 and o_Collided=0.
REQ-027 Rows 6-8 and 14 give code 0, with o_Collided=0 and o_On_Log=0.
REQ-028 o_Log_Shift=1 when the frog's water lane shifts in cycle n and its bit at i_Frogger_X is set in cycle n (pre-shift).
REQ-029 X>13 or Y>14: code 0 and all flags 0.
REQ-030 i_Game_Active=0: prescaler, dividers and patterns hold their values; o_Collided, o_On_Log and o_Log_Shift are 0; o_Bitmap_Data is still computed.
REQ-031 i_Game_Active rising: the prescaler resumes from its held count, with no extra step pulse.

Reset
REQ-032 While i_Reset is high: prescaler and dividers reset to 0; outputs reset to 0, 0, 0, 0; patterns load the REQ-033 values.
REQ-033 Reset lane patterns (occupied columns):
- row 1: 0-3, 7-10
- row 2: 2-5, 10-12
- row 3: 0-2, 5-7, 10-11
- row 4: 3-8
- row 5: 1-3, 8-10
- row 9: 0, 7
- row 10: 3, 4, 10
- row 11: 1, 6, 11
- row 12: 5, 12
- row 13: 2, 3, 9
REQ-034 Reset has priority over i_Game_Active; reset asserted mid-step discards any pending shift.

Verification (c_STEP_COUNT=4)
REQ-035 Reset; Y=9, X=0, active -> cycle 1 after reset release: o_Collided=1, code 5; X=1 -> next cycle: o_Collided=0, code 1.
REQ-036 Y=9, X=13, active -> the first shift (after 4 cycles) wraps bit 0 to column 13: o_Collided=1 one cycle after the shift.
REQ-037 Y=1, X=0, active -> o_On_Log=1, code 3; on the 3rd step pulse: o_Log_Shift pulses exactly once, for 1 cycle.
REQ-038 Y=10 -> after 2 step pulses, cars sit at columns 4, 5 and 11; the frog at X=11 gives o_Collided=1.
REQ-039 Y=0, X=4 -> code 4; X=5 -> code 6; Y=7 -> code 0 with all flags 0.
REQ-040 Deassert i_Game_Active for 20 cycles -> patterns unchanged and flags 0; assert i_Reset mid-run -> REQ-033 patterns restored on the next edge.
